// File: rtl/sfq_capture_pkg.sv
// Shared types and constants for the SFQ toggle capture block.
// Holds the capture FSM state type, arm length, default sizing and a saturating add.
// No ports; imported by sfq_toggle_capture and sfq_capture_fifo.
package sfq_capture_pkg;

    typedef enum logic {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_e;

    // Cycles spent re-learning the input levels after reset release.
    localparam int ARM_CYCLES = 3;
    localparam int ARM_W      = 2;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_DEPTH = 4;

    // a + b clamped to 2^w - 1; w must be 31 or less.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
        logic [32:0] sum;
        logic [32:0] max_v;
        max_v = (33'd1 << w) - 33'd1;
        sum   = {1'b0, a} + {1'b0, b};
        if (sum > max_v) begin
            return max_v[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/sfq_capture_fifo.sv
// Synchronous FIFO holding closed frame snapshots, with full/empty flags.
// Latency: a push is visible at the head after the write edge; a pop exposes the next entry after the edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
// Ports: clk/rst, push_i/push_dat_i, pop_i, full_o, empty_o, head_dat_o (zero when empty).
module sfq_capture_fifo
    import sfq_capture_pkg::*;
#(
    parameter int DW    = 18,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_dat_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    // Full plus a same-cycle pop frees the slot being written.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sfq_toggle_capture.sv
// Captures toggle-encoded SFQ outputs: synchronizes, converts level changes to pulses, counts per frame.
// Latency: tog_in edge before edge k is counted at edge k+2; a frame at edge f is at the FIFO head after f.
// Backpressure: out_valid/out_ready; a frame closing while the FIFO is full and not popping is dropped, setting lost.
// Ports: clk, rst, tog_in, frame, out_valid, out_ready, out_counts, out_ovf, lost.
module sfq_toggle_capture
    import sfq_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       tog_in,
    input  logic                   frame,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*CNT_W-1:0] out_counts,
    output logic [WIDTH-1:0]       out_ovf,
    output logic                   lost
);

    localparam int               DW      = WIDTH * (CNT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                       state_q, state_d;
    logic [ARM_W-1:0]             arm_cnt_q, arm_cnt_d;
    logic [WIDTH-1:0]             s1_q, s2_q, p_q;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]             ovf_q, ovf_d;
    logic                         lost_q, lost_d;

    logic [WIDTH-1:0]             pulse;
    logic [WIDTH-1:0][CNT_W-1:0]  snap_cnt;
    logic [WIDTH-1:0]             snap_ovf;
    logic                         snap_push;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_pop;
    logic [DW-1:0]                fifo_head;
    logic [31:0]                  sat_tmp;

    assign pulse = s2_q ^ p_q;

    // Input synchronizers and previous-level register. p follows s2 in both
    // states, so during arming any level present at reset release is absorbed
    // without producing a counted pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            p_q  <= '0;
        end else begin
            s1_q <= tog_in;
            s2_q <= s1_q;
            p_q  <= s2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARM;
            arm_cnt_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= '0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            lost_q    <= lost_d;
        end
    end

    assign fifo_pop = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        lost_d    = lost_q;
        snap_cnt  = '0;
        snap_ovf  = '0;
        snap_push = 1'b0;
        sat_tmp   = '0;

        case (state_q)
            ST_ARM: begin
                arm_cnt_d = arm_cnt_q + 1'b1;
                if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                snap_push = frame;
                for (int i = 0; i < WIDTH; i++) begin
                    if (frame) begin
                        // A pulse landing in the frame cycle closes with this window.
                        sat_tmp     = sat_add(32'(cnt_q[i]), 32'(pulse[i]), CNT_W);
                        snap_cnt[i] = sat_tmp[CNT_W-1:0];
                        snap_ovf[i] = ovf_q[i] || (pulse[i] && (cnt_q[i] == CNT_MAX));
                        cnt_d[i]    = '0;
                        ovf_d[i]    = 1'b0;
                    end else if (pulse[i]) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            ovf_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                if (frame && fifo_full && !fifo_pop) begin
                    lost_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    sfq_capture_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (snap_push),
        .push_dat_i ({snap_ovf, snap_cnt}),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (fifo_head)
    );

    assign out_valid  = !fifo_empty;
    assign out_counts = fifo_head[WIDTH*CNT_W-1:0];
    assign out_ovf    = fifo_head[DW-1 -: WIDTH];
    assign lost       = lost_q;

endmodule

// File: tb/tb_sfq_toggle_capture.sv
// Bench for sfq_toggle_capture: directed scenarios plus randomized toggles/frames/ready.
// Reference model counts pulses per window with plain integers and keeps frames in queues.
// Outputs are compared every cycle on the falling edge.
module tb_sfq_toggle_capture;

    localparam int W    = 2;
    localparam int CW   = 8;
    localparam int D    = 4;
    localparam int MAXC = 255;
    localparam int NP   = 65536;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    tog_in;
    logic            frame;
    logic            out_ready;
    logic            out_valid;
    logic [W*CW-1:0] out_counts;
    logic [W-1:0]    out_ovf;
    logic            lost;

    always #5 clk = ~clk;

    sfq_toggle_capture #(
        .WIDTH (W),
        .CNT_W (CW),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tog_in     (tog_in),
        .frame      (frame),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_counts (out_counts),
        .out_ovf    (out_ovf),
        .lost       (lost)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int              edge_idx  = 0;
    int              run_start = 1 << 30;
    int              mcnt [W];
    int              last_tog [W];
    logic [W*CW-1:0] q_cnt [$];
    logic [W-1:0]    q_ovf [$];
    logic            m_lost;
    bit              pend [W][NP];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_idx);
        end
    endtask

    task automatic model_clear();
        for (int ch = 0; ch < W; ch++) mcnt[ch] = 0;
        q_cnt.delete();
        q_ovf.delete();
        m_lost    = 1'b0;
        run_start = 1 << 30;
    endtask

    // One rising edge e: pulses scheduled for e are counted if capture is running.
    task automatic model_edge(input int e);
        logic            pop;
        logic            do_frame;
        logic [W*CW-1:0] nc;
        logic [W-1:0]    no;
        int              n;
        int              pl;
        if (rst) begin
            model_clear();
        end else begin
            pop      = (q_cnt.size() > 0) && out_ready;
            do_frame = frame && (e >= run_start);
            nc       = '0;
            no       = '0;
            for (int ch = 0; ch < W; ch++) begin
                pl = pend[ch][e % NP] ? 1 : 0;
                pend[ch][e % NP] = 1'b0;
                if (e >= run_start) begin
                    n = mcnt[ch] + pl;
                    if (do_frame) begin
                        nc[ch*CW +: CW] = (n > MAXC) ? CW'(MAXC) : CW'(n);
                        no[ch]          = (n > MAXC);
                        mcnt[ch]        = 0;
                    end else begin
                        mcnt[ch] = n;
                    end
                end
            end
            if (pop) begin
                void'(q_cnt.pop_front());
                void'(q_ovf.pop_front());
            end
            if (do_frame) begin
                if (q_cnt.size() < D) begin
                    q_cnt.push_back(nc);
                    q_ovf.push_back(no);
                end else begin
                    m_lost = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(edge_idx);
        edge_idx++;
        @(negedge clk);
        check_eq("valid", out_valid, q_cnt.size() > 0);
        check_eq("counts", out_counts, (q_cnt.size() > 0) ? q_cnt[0] : '0);
        check_eq("ovf", out_ovf, (q_ovf.size() > 0) ? q_ovf[0] : '0);
        check_eq("lost", lost, m_lost);
    endtask

    // Toggle after edge j is synchronized by j+2 and seen as a pulse at edge j+3.
    task automatic toggle(input int ch);
        tog_in[ch]                     = ~tog_in[ch];
        pend[ch][(edge_idx + 2) % NP] = 1'b1;
        last_tog[ch]                   = edge_idx;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        tick();
        tick();
        rst       = 1'b0;
        run_start = edge_idx + 3;
    endtask

    task automatic close_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pops;
        rst       = 1'b1;
        tog_in    = 2'b11;
        frame     = 1'b0;
        out_ready = 1'b0;
        for (int ch = 0; ch < W; ch++) last_tog[ch] = -10;
        model_clear();

        // Inputs high through reset release must not count.
        do_reset();
        wait_cycles(10);
        close_frame();
        check_eq("t1_valid", out_valid, 1'b1);
        check_eq("t1_counts", out_counts, 16'h0000);
        check_eq("t1_lost", lost, 1'b0);
        pop_one();

        // Three ch0 edges, one ch1 edge.
        for (int k = 0; k < 3; k++) begin
            toggle(0);
            if (k == 0) toggle(1);
            wait_cycles(4);
        end
        close_frame();
        check_eq("t2_counts", out_counts, {8'd1, 8'd3});
        pop_one();
        check_eq("t2_empty", out_valid, 1'b0);

        // Saturation then a clean window.
        for (int k = 0; k < 300; k++) begin
            toggle(0);
            wait_cycles(2);
        end
        wait_cycles(3);
        close_frame();
        check_eq("t3_sat", out_counts[7:0], 8'd255);
        check_eq("t3_ovf", out_ovf, 2'b01);
        pop_one();
        wait_cycles(2);
        close_frame();
        check_eq("t3_clear", out_counts, 16'h0000);
        check_eq("t3_clear_ovf", out_ovf, 2'b00);
        pop_one();

        // Pulse-detect cycle coincides with the frame.
        toggle(1);
        wait_cycles(2);
        close_frame();
        check_eq("t4_edge", out_counts, {8'd1, 8'd0});
        pop_one();
        wait_cycles(3);
        close_frame();
        check_eq("t4_next", out_counts, 16'h0000);
        pop_one();

        // Five frames without ready: counts 0..3 queued, the fifth dropped.
        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < k; t++) begin
                toggle(0);
                wait_cycles(2);
            end
            wait_cycles(3);
            close_frame();
        end
        check_eq("t5_lost", lost, 1'b1);
        check_eq("t5_head", out_counts, {8'd0, 8'd0});
        frame     = 1'b1;
        out_ready = 1'b1;
        tick();
        frame     = 1'b0;
        out_ready = 1'b0;
        check_eq("t5_head2", out_counts, {8'd0, 8'd1});
        pops      = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) pops++;
            tick();
        end
        out_ready = 1'b0;
        check_eq("t5_pops", pops, 4);

        // Reset with three frames queued.
        frame = 1'b1;
        wait_cycles(3);
        frame = 1'b0;
        rst   = 1'b1;
        #1;
        check_eq("t6_valid", out_valid, 1'b0);
        check_eq("t6_lost", lost, 1'b0);
        check_eq("t6_counts", out_counts, 16'h0000);
        model_clear();
        @(negedge clk);
        do_reset();
        wait_cycles(4);
        toggle(1);
        wait_cycles(3);
        toggle(1);
        wait_cycles(4);
        close_frame();
        check_eq("t6_resume", out_counts, {8'd2, 8'd0});
        pop_one();

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            for (int ch = 0; ch < W; ch++) begin
                if ((edge_idx - last_tog[ch]) >= 2 && ($urandom % 3) == 0) toggle(ch);
            end
            frame     = (($urandom % 6) == 0);
            out_ready = (c < 1000) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
